bit_serial_tx: RTL and testbench
================================

# bit_serial_tx

Parallel-to-bit-serial word transmitter for the bit-serial datapath. It accepts W-bit words over a valid/ready handshake and buffers them in a small FIFO. It emits them MSB-first, one bit per bit-clock period, on the play edge (falling `bclk`), so downstream bit-serial stages can capture on the record edge (rising `bclk`). It is the producer that feeds the serial inputs of the delay lines and arithmetic stages from word-level logic.

## Interface
- `W`, 32, word width in bits (≥2)
- `DEPTH`, 2, FIFO entries (power of two, ≥2)

- `clk`  in  1  system clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `bclk`  in  1  bit clock, synchronous to `clk`, each level held ≥1 `clk` cycle
- `in_data`  in  W  parallel word
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  FIFO can accept a word
- `out`  out  1  serial bit, MSB first
- `frame`  out  1  high while `out` carries bit W-1 (first bit) of a word
- `underrun`  out  1  one-`clk` pulse: a play edge found no word to send
- `busy`  out  1  a word is in flight or the FIFO is non-empty

## Operation
- Edge detect: register `bclk_prev` (reset 0).
  - Play edge = `bclk_prev && !bclk`.
  - Record edge = `!bclk_prev && bclk`. The record edge has no effect in this block.
- FIFO: `DEPTH` entries with a count register of width clog2(DEPTH)+1.
  - `in_ready = (count != DEPTH)`, combinational from the registered count.
  - A push occurs when `in_valid && in_ready`.
- Shifter: W-bit shift register `sh` and bit counter `bits_left` (0..W).
- On a play edge with `bits_left > 1`:
  - `out <= sh[W-2]`, shift `sh` left, `bits_left--`, `frame <= 0`.
- On a play edge with `bits_left <= 1` (idle or last bit just sent):
  - FIFO non-empty: pop the head and load `sh`. Then `out <= head[W-1]`, `frame <= 1`, `bits_left <= W`.
  - FIFO empty: `out <= 0`, `frame <= 0`, `bits_left <= 0`. Pulse `underrun` only if `bits_left` was 1, i.e. the stream stops mid-flow. From idle (`bits_left` = 0) no pulse is issued.
- Words stream back-to-back with no gap bits as long as the FIFO stays non-empty.
- Simultaneous push and pop in one cycle:
  - Both take effect and `count` is unchanged.
  - When full, the push is refused that cycle because `in_ready` was low. No bypass.
- Push into an empty FIFO on the same cycle as a play edge: the word is not visible to that play edge. It is sent on the next play edge.
- `busy = (bits_left != 0) || (count != 0)`.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk`):
  - `out`=0, `frame`=0, `underrun`=0, `busy`=0, `in_ready`=1.
  - FIFO empty, `bits_left`=0, `bclk_prev`=0.
- Play-edge latency: `out` and `frame` update on the `clk` posedge where `bclk_prev`=1 and `bclk`=0 are sampled. That is one `clk` after `bclk` is seen low.
- `out` is held stable for the entire bit period until the next play edge.
- First bit latency from an accepted push into an idle block: the first play edge strictly after the push cycle.
- `underrun` is high for exactly one `clk`, in the same cycle that `out` updates.
- `bclk` high at reset release: the first cycle sees a record edge, which is ignored. No spurious play edge occurs.
- Reset mid-word discards the FIFO contents and the partially sent word. `out` goes to 0 immediately.

## Test plan
- Single word, W=32, `in_data`=0x8000_0001, `bclk` = 2 `clk` low / 2 high:
  - `out` sequence over 32 play edges is 1, thirty 0s, 1.
  - `frame` high only during the first bit.
  - `busy` falls on the next play edge after bit 0 completes.
- Back-to-back 0xFFFF_0000 then 0x1234_5678, pushed before the first play edge:
  - 64 contiguous bits with no gap.
  - `frame` asserted at bit 0 and at bit 32.
  - No `underrun`.
- FIFO full: push 3 words with `bclk` stopped.
  - `in_ready` drops after 2 accepts.
  - The third word is accepted in the cycle after the first pop.
  - All 3 words are sent in order.
- Underrun: one word sent with no refill.
  - On the 33rd play edge `underrun` pulses 1 cycle and `out`=0.
  - No further pulses on later idle play edges.
- Reset mid-word: assert `rst_n`=0 after 10 bits of 0xA5A5_A5A5.
  - `out`, `frame`, `busy` = 0 and `in_ready` = 1 immediately.
  - After release, a new word 0x0000_0003 is sent cleanly from its MSB.
- Simultaneous push and play edge on an empty FIFO:
  - That play edge outputs 0 and causes no `underrun`.
  - The word's MSB appears on the following play edge.

Source files
------------

// File: rtl/bit_serial_tx.sv
// bit_serial_tx: parallel-to-bit-serial word transmitter.
// Words arrive over valid/ready into a small FIFO. They are shifted out MSB-first,
// one bit per bit-clock period, on the falling edge of bclk (the play edge), so
// downstream bit-serial stages can capture on the rising edge.
module bit_serial_tx #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bclk,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out,
    output logic         frame,
    output logic         underrun,
    output logic         busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(W + 1);

    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [BW-1:0] BITS_W = BW'(W);
    localparam logic [BW-1:0] ONE    = BW'(1);
    localparam logic [PW-1:0] PTR1   = PW'(1);
    localparam logic [CW-1:0] CNT1   = CW'(1);

    logic          bclk_prev_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [W-1:0]  sh_q;
    logic [W-1:0]  sh_d;
    logic [BW-1:0] bits_left_q;
    logic [BW-1:0] bits_left_d;
    logic          out_q;
    logic          out_d;
    logic          frame_q;
    logic          frame_d;
    logic          underrun_q;
    logic          underrun_d;

    logic          play;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [W-1:0]  head;

    // The record edge (rising bclk) has no effect here, so only the play edge is decoded.
    assign play       = bclk_prev_q & ~bclk;
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != FULL);
    assign push       = in_valid & in_ready;
    assign head       = mem_q[rd_ptr_q];
    // Popping uses the registered count, so a word pushed this cycle is invisible
    // to a play edge in the same cycle.
    assign pop        = play && (bits_left_q <= ONE) && !fifo_empty;

    assign out      = out_q;
    assign frame    = frame_q;
    assign underrun = underrun_q;
    assign busy     = (bits_left_q != '0) || (count_q != '0);

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT1;
            2'b01:   count_d = count_q - CNT1;
            default: count_d = count_q;
        endcase
    end

    // Shifter next state: shift mid-word, reload from the FIFO at a word boundary,
    // or drop to idle and flag an underrun if a stream stops mid-flow.
    always_comb begin
        sh_d        = sh_q;
        bits_left_d = bits_left_q;
        out_d       = out_q;
        frame_d     = frame_q;
        underrun_d  = 1'b0;
        if (play) begin
            if (bits_left_q > ONE) begin
                out_d       = sh_q[W-2];
                sh_d        = {sh_q[W-2:0], 1'b0};
                bits_left_d = bits_left_q - ONE;
                frame_d     = 1'b0;
            end else if (!fifo_empty) begin
                sh_d        = head;
                out_d       = head[W-1];
                frame_d     = 1'b1;
                bits_left_d = BITS_W;
            end else begin
                out_d       = 1'b0;
                frame_d     = 1'b0;
                bits_left_d = '0;
                underrun_d  = (bits_left_q == ONE);
            end
        end
    end

    // Control state: edge detector, FIFO pointers/count, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_prev_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bits_left_q <= '0;
            out_q       <= 1'b0;
            frame_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bclk_prev_q <= bclk;
            if (push) wr_ptr_q <= wr_ptr_q + PTR1;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR1;
            count_q     <= count_d;
            bits_left_q <= bits_left_d;
            out_q       <= out_d;
            frame_q     <= frame_d;
            underrun_q  <= underrun_d;
        end
    end

    // Word storage and shift register carry data only; control decides when they matter.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
        sh_q <= sh_d;
    end

endmodule

// File: tb/tb_bit_serial_tx.sv
// Bench for bit_serial_tx: directed words, scoreboard queue of accepted words,
// independent monitor checking every cycle plus hand-computed spot checks.
module tb_bit_serial_tx;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         bclk     = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out;
    logic         frame;
    logic         underrun;
    logic         busy;

    bit_serial_tx #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bclk     (bclk),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .frame    (frame),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] w;
        int           cyc;
    } ent_t;

    ent_t sb[$];

    int vec = 0;
    int miss = 0;
    int cyc = 0;

    // monitor model state
    logic         prev_m = 1'b0;
    logic [W-1:0] cur_m = '0;
    int           bl_m = 0;
    logic         exp_out = 1'b0;
    logic         exp_frame = 1'b0;
    logic         m_play;
    logic         m_under;
    int           m_n;

    int           play_cnt = 0;
    int           under_cnt = 0;
    int           frame_cnt = 0;
    int           wbits = 0;
    logic [63:0]  cap = '0;

    // bclk generator state (advanced by the stimulus)
    bit bclk_run = 0;
    int ph = 0;
    bit fell = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: model the transmitter from accepted words and compare every cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_play  = prev_m && !bclk && rst_n;
            prev_m  = rst_n ? bclk : 1'b0;
            m_under = 1'b0;
            if (!rst_n) begin
                sb.delete();
                bl_m      = 0;
                exp_out   = 1'b0;
                exp_frame = 1'b0;
            end else if (m_play) begin
                if (bl_m > 1) begin
                    exp_out   = cur_m[bl_m-2];
                    exp_frame = 1'b0;
                    bl_m--;
                end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    cur_m     = sb[0].w;
                    void'(sb.pop_front());
                    exp_out   = cur_m[W-1];
                    exp_frame = 1'b1;
                    bl_m      = W;
                end else begin
                    m_under   = (bl_m == 1);
                    exp_out   = 1'b0;
                    exp_frame = 1'b0;
                    bl_m      = 0;
                end
            end
            m_n = 0;
            foreach (sb[i]) if (sb[i].cyc <= cyc) m_n++;
            #1;
            chk("out",      64'(out),      64'(exp_out));
            chk("frame",    64'(frame),    64'(exp_frame));
            chk("underrun", 64'(underrun), 64'(m_under));
            chk("busy",     64'(busy),     64'((bl_m != 0) || (m_n != 0)));
            chk("in_ready", 64'(in_ready), 64'(m_n != DEPTH));
            if (m_play) begin
                play_cnt++;
                if (bl_m != 0) begin
                    cap = {cap[62:0], out};
                    wbits++;
                end
                if (frame) frame_cnt++;
            end
            if (underrun) under_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        fell = 0;
        if (bclk_run) begin
            ph++;
            if (ph == 2) begin
                ph   = 0;
                bclk = ~bclk;
                fell = !bclk;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [W-1:0] w);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 500) begin
            step();
            t++;
        end
        if (!in_ready) begin
            chk("push_accept", 64'(in_ready), 64'd1);
        end else begin
            sb.push_back('{w: w, cyc: cyc + 1});
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_fall();
        int t;
        t = 0;
        do begin
            step();
            t++;
        end while (!fell && t < 20);
        chk("bclk_fall", 64'(fell), 64'd1);
    endtask

    int fc;
    int uc;
    int b0;

    initial begin
        #1 rst_n = 1'b0;
        steps(3);
        chk("rst_out",      64'(out),      64'd0);
        chk("rst_frame",    64'(frame),    64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // single word, then underrun at the 33rd play edge
        cap = '0;
        push(32'h8000_0001);
        bclk_run = 1;
        steps(160);
        chk("t1_bits",      cap,              64'h0000_0000_8000_0001);
        chk("t1_underruns", 64'(under_cnt),   64'd1);

        // back-to-back words queued before the first play edge
        bclk_run = 0;
        cap = '0;
        fc  = frame_cnt;
        push(32'hFFFF_0000);
        push(32'h1234_5678);
        bclk_run = 1;
        steps(64 * 4 + 24);
        chk("t2_bits",      cap,                   64'hFFFF_0000_1234_5678);
        chk("t2_frames",    64'(frame_cnt - fc),   64'd2);
        chk("t2_underruns", 64'(under_cnt),        64'd2);

        // FIFO full with bclk stopped; third word waits for the first pop
        bclk_run = 0;
        push(32'h0F0F_0F0F);
        push(32'hDEAD_BEEF);
        chk("t3_full", 64'(in_ready), 64'd0);
        bclk_run = 1;
        push(32'h1357_9BDF);
        steps(96 * 4 + 24);
        chk("t3_bits",      cap,             64'hDEAD_BEEF_1357_9BDF);
        chk("t3_underruns", 64'(under_cnt),  64'd3);
        steps(40);
        chk("idle_no_pulse", 64'(under_cnt), 64'd3);

        // reset mid-word
        b0 = wbits;
        push(32'hA5A5_A5A5);
        for (int t = 0; t < 200 && (wbits - b0) < 10; t++) step();
        chk("t5_bits_sent", 64'(wbits - b0), 64'd10);
        chk("t5_busy_pre",  64'(busy),       64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_out",      64'(out),      64'd0);
        chk("t5_frame",    64'(frame),    64'd0);
        chk("t5_busy",     64'(busy),     64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        steps(3);
        rst_n = 1'b1;
        step();
        cap = '0;
        push(32'h0000_0003);
        steps(160);
        chk("t5_new_word",  cap,            64'h0000_0000_0000_0003);
        chk("t5_underruns", 64'(under_cnt), 64'd4);

        // push into an empty FIFO on the same cycle as a play edge
        wait_fall();
        uc = under_cnt;
        push(32'hC000_0000);
        chk("t6_out_zero",  64'(out),       64'd0);
        chk("t6_no_under",  64'(under_cnt), 64'(uc));
        steps(4);
        chk("t6_msb",       64'(out),       64'd1);
        chk("t6_frame",     64'(frame),     64'd1);
        steps(160);
        chk("t6_underruns", 64'(under_cnt), 64'(uc + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
